data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder for the RISC-V core's load/store path. It accepts one load or store request at a time over a valid/ready request channel and performs the byte/half/word access with the RISC-V lane and sign-extension rules. After a programmable number of wait states it returns the result over a valid/ready response channel. It replaces the zero-latency data memory when the core moves to a stall-capable memory interface, and it also serves as the bench model for that interface.

## Interface
- ADDR_W, 10, word-address width; depth = 2^ADDR_W 32-bit words; valid byte range 0 .. 4*2^ADDR_W-1
- WAIT, 2, wait states between accept and memory access (0..15)
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store (sb/sh/sw), 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal
- req_unsigned  input  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data, right-aligned (rs2)
- rsp_valid  output  1  response present
- rsp_ready  input  1  core consumes response
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  request faulted
- err_cnt  output  8  saturating count of faulted requests

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/size/unsigned/addr/wdata and load the wait counter with WAIT.
  - Next state is WAIT if WAIT>0, else RESP.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Access edge: the edge entering RESP.
  - The memory read or write happens on this edge.
  - rsp_rdata and rsp_err are registered on this edge.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err stay stable until rsp_valid&rsp_ready; on that edge go to IDLE.
- Fault conditions (rsp_err=1, no write, rsp_rdata=0):
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=00.
  - addr[31:ADDR_W+2] != 0.
- Store lanes (word index addr[ADDR_W+1:2]):
  - sb writes wdata[7:0] into byte addr[1:0].
  - sh writes wdata[15:0] into half addr[1].
  - sw writes all 4 bytes.
  - All other bytes are unchanged.
- Load extraction:
  - Select the byte or half indicated by addr.
  - Extend to 32 bits: sign-extend if req_unsigned=0, else zero-extend.
  - req_unsigned is ignored for word loads and for stores.
- err_cnt increments on each faulted access edge and saturates at 255.
- Memory contents are not reset.

## Timing
- Reset values:
  - State IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0.
  - No request is accepted while rst=0.
- Latency: accept edge at cycle N puts rsp_valid=1 in cycle N+WAIT+1.
- Minimum throughput: one request per WAIT+2 cycles. req_ready returns in the cycle after the response handshake, so there is no same-cycle accept and respond.
- rsp_ready low in RESP holds the response indefinitely; req_ready stays 0.
- rsp_ready high outside RESP has no effect.
- req_valid while req_ready=0 is ignored. The requester holds its request until accepted.
- Reset asserted mid-operation:
  - Aborts immediately; all outputs go to their reset values.
  - A store before its access edge is never committed.
  - A store whose access edge has passed remains in memory.

## Test plan
- WAIT=2. sw addr 0x10 data 0xDEADBEEF accepted at cycle N -> rsp_valid at N+3, rsp_err=0, rsp_rdata=0. Then lw 0x10 -> rsp_rdata=0xDEADBEEF.
- After that word:
  - sb 0x12 data 0x0000007F, then lw 0x10 -> 0xDE7FBEEF.
  - lb 0x13 -> 0xFFFFFFDE.
  - lbu 0x13 -> 0x000000DE.
  - lh 0x10 -> 0xFFFFBEEF.
  - lhu 0x10 -> 0x0000BEEF.
- Misaligned and illegal requests:
  - lw 0x11 -> rsp_err=1, rsp_rdata=0.
  - sh 0x13 -> rsp_err=1, memory unchanged (lw 0x10 still 0xDE7FBEEF).
  - Size 11 -> rsp_err=1.
  - err_cnt=3 after these three.
- ADDR_W=10. lw 0x1000 -> rsp_err=1. lw 0xFFC -> rsp_err=0 (last word).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. Assert rsp_ready -> IDLE next cycle, req_ready=1.
- Reset mid-op and edge cases:
  - sw 0x20 data 0x12345678 accepted, rst=0 during WAIT -> outputs reset immediately. After release, lw 0x20 returns the prior contents.
  - WAIT=0 -> rsp_valid in cycle N+1.
  - 300 faults -> err_cnt=255.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the RISC-V load/store path.
// It handles one request at a time: accept, a programmable number of wait states, access, then respond.
module data_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we, l_uns;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] mem [DEPTH];

  logic              a_we, a_uns;
  logic [1:0]        a_size;
  logic [31:0]       a_addr, a_wdata;
  logic              fault, access;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word, ld_data, rd_result, wr_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        be;

  // With zero wait states the access edge is the accept edge, so the live request is used.
  always_comb begin
    if (state == S_IDLE) begin
      a_we    = req_we;
      a_uns   = req_unsigned;
      a_size  = req_size;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end else begin
      a_we    = l_we;
      a_uns   = l_uns;
      a_size  = l_size;
      a_addr  = l_addr;
      a_wdata = l_wdata;
    end
  end

  assign access = rst && (((state == S_IDLE) && req_valid && req_ready && (WAIT == 0)) ||
                          ((state == S_WAIT) && (cnt == 4'd1)));

  assign fault = (a_size == 2'b11) ||
                 ((a_size == 2'b01) && a_addr[0]) ||
                 ((a_size == 2'b10) && (a_addr[1:0] != 2'b00)) ||
                 (a_addr[31:ADDR_W+2] != '0);

  assign idx  = a_addr[ADDR_W+1:2];
  assign word = mem[idx];

  always_comb begin
    ld_byte = 8'h00;
    case (a_addr[1:0])
      2'd0:    ld_byte = word[7:0];
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    ld_half = a_addr[1] ? word[31:16] : word[15:0];

    ld_data = word;
    case (a_size)
      2'b00:   ld_data = {{24{~a_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~a_uns & ld_half[15]}}, ld_half};
      default: ld_data = word;
    endcase
    rd_result = (fault || a_we) ? 32'h0 : ld_data;

    be      = 4'b1111;
    wr_data = a_wdata;
    case (a_size)
      2'b00: begin
        be      = 4'b0001 << a_addr[1:0];
        wr_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be      = a_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{a_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = a_wdata;
      end
    endcase
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (access && a_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      err_cnt   <= 8'h00;
      l_we      <= 1'b0;
      l_uns     <= 1'b0;
      l_size    <= 2'b00;
      l_addr    <= 32'h0;
      l_wdata   <= 32'h0;
    end else begin
      if (access) begin
        rsp_rdata <= rd_result;
        rsp_err   <= fault;
        if (fault && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            l_we      <= req_we;
            l_uns     <= req_unsigned;
            l_size    <= req_size;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            cnt       <= 4'(WAIT);
            req_ready <= 1'b0;
            if (WAIT == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected responses,
// a monitor pops them on each response handshake and also checks latency.
module tb_data_mem_responder;
  localparam int WAIT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_cnt;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, req_unsigned0 = 1'b0, rsp_ready0 = 1'b1;
  logic [1:0]  req_size0 = 2'b00;
  logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [7:0]  err_cnt0;

  int   cyc = 0;
  int   n_vec = 0, n_bad = 0;
  exp_t sb[$];

  data_mem_responder #(.ADDR_W(10), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_cnt(err_cnt)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_size(req_size0), .req_unsigned(req_unsigned0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .err_cnt(err_cnt0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake.
  initial begin
    bit   seen;
    int   first;
    exp_t e;
    seen  = 1'b0;
    first = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen = 1'b0;
      end else begin
        if (rsp_valid && !seen) begin
          seen  = 1'b1;
          first = cyc;
        end
        if (rsp_valid && rsp_ready) begin
          seen = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("latency", 32'(first - e.acc), 32'(WAIT + 1));
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.rdata = er; e.err = ee; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic issue0(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er);
    int n, acc;
    @(posedge clk); #1;
    req_we0 = we; req_size0 = sz; req_unsigned0 = uns; req_addr0 = a; req_wdata0 = wd;
    req_valid0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready0 && n < 50);
    acc = cyc;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    n = 0;
    while (!rsp_valid0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w0_latency", 32'(cyc - acc), 32'd1);
    chk("w0_rdata", rsp_rdata0, er);
    chk("w0_err", {31'd0, rsp_err0}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    issue(1, 2'b00, 0, 32'h12, 32'h0000007F, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDE7FBEEF, 0);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0);
    issue(0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
    issue(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0);
    issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDE7F, 0);
    issue(0, 2'b00, 0, 32'h12, 32'h0, 32'h0000007F, 0);

    issue(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
    issue(1, 2'b01, 0, 32'h13, 32'h0000AAAA, 32'h0, 1);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    drain();
    chk("err_cnt_3", {24'd0, err_cnt}, 32'd3);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDE7FBEEF, 0);

    issue(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
    issue(1, 2'b10, 0, 32'hFFC, 32'h0BADF00D, 32'h0, 0);
    issue(0, 2'b10, 0, 32'hFFC, 32'h0, 32'h0BADF00D, 0);
    drain();
    chk("err_cnt_4", {24'd0, err_cnt}, 32'd4);

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDE7FBEEF, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDE7FBEEF);
      chk("bp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);

    issue(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    for (int i = 0; i < 296; i++) issue(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
    drain();
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Store aborted by reset while still in its wait states.
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);
    issue(0, 2'b01, 1, 32'h22, 32'h0, 32'h0000CAFE, 0);
    drain();

    issue0(1, 2'b10, 0, 32'h4, 32'hA5A5A5A5, 32'h0);
    issue0(0, 2'b01, 0, 32'h6, 32'h0, 32'hFFFFA5A5);
    issue0(0, 2'b00, 1, 32'h5, 32'h0, 32'h000000A5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
